// File: rtl/crc8_pkg.sv
// Shared types and constants for the CRC-8 frame controller and its engine.
package crc8_pkg;

    typedef enum logic {
        DATA  = 1'b0,
        FINAL = 1'b1
    } state_e;

    localparam int          MODE_APPEND = 0;
    localparam int          MODE_CHECK  = 1;
    localparam logic [7:0]  CRC_INIT    = 8'h00;

endpackage

// File: rtl/crc8.sv
// Byte-wide CRC-8 engine: MSB-first, no reflection, no final xor.
// crc_o is the registered CRC of all bytes accepted since the last reset.
module crc8
    import crc8_pkg::*;
#(
    parameter logic [7:0] POLYNOMIAL = 8'h07
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] data_i,
    input  logic       data_valid_i,
    output logic [7:0] crc_o
);

    logic [7:0] crc_q;
    logic [7:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (data_valid_i) begin
            crc_d = crc_q ^ data_i;
            for (int i = 0; i < 8; i++) begin
                crc_d = crc_d[7] ? ({crc_d[6:0], 1'b0} ^ POLYNOMIAL) : {crc_d[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            crc_q <= CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/crc8_frame_ctrl.sv
// Frame sequencer around one crc8 engine: passes bytes through and either
// appends the CRC byte (MODE_APPEND) or checks the trailing CRC byte (MODE_CHECK).
module crc8_frame_ctrl
    import crc8_pkg::*;
#(
    parameter int         MODE       = 0,
    parameter logic [7:0] POLYNOMIAL = 8'h07,
    parameter int         LEN_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       s_data_i,
    input  logic             s_valid_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    output logic [7:0]       m_data_o,
    output logic             m_valid_o,
    output logic             m_last_o,
    input  logic             m_ready_i,
    output logic             frame_done_o,
    output logic             crc_err_o,
    output logic [LEN_W-1:0] frame_len_o,
    output logic             busy_o
);

    // Handshake: a byte moves on a channel in any cycle where valid and ready
    // are both high; valid never depends on ready, and ready may depend on valid.

    localparam logic [LEN_W-1:0] CNT_MAX = '1;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             err_q, err_d;
    logic             eng_clr;
    logic             eng_valid;
    logic             frame_end;
    logic [7:0]       crc;

    crc8 #(
        .POLYNOMIAL (POLYNOMIAL)
    ) u_crc8 (
        .clk_i        (clk_i),
        .rst_i        (rst_i | eng_clr),
        .data_i       (s_data_i),
        .data_valid_i (eng_valid),
        .crc_o        (crc)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        len_d        = len_q;
        err_d        = err_q;
        eng_clr      = 1'b0;
        eng_valid    = 1'b0;
        frame_end    = 1'b0;
        s_ready_o    = 1'b0;
        m_valid_o    = 1'b0;
        m_data_o     = s_data_i;
        m_last_o     = 1'b0;
        frame_done_o = 1'b0;

        case (state_q)
            DATA: begin
                s_ready_o = m_ready_i;
                m_valid_o = s_valid_i;
                m_last_o  = (MODE == MODE_CHECK) ? (s_valid_i & s_last_i) : 1'b0;
                if (s_valid_i && m_ready_i) begin
                    eng_valid = 1'b1;
                    if (count_q != CNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                    if (s_last_i) begin
                        state_d = FINAL;
                    end
                end
            end
            FINAL: begin
                if (MODE == MODE_APPEND) begin
                    m_valid_o = 1'b1;
                    m_data_o  = crc;
                    m_last_o  = 1'b1;
                    frame_end = m_ready_i;
                end else begin
                    frame_end = 1'b1;
                end
            end
            default: state_d = DATA;
        endcase

        // Engine is cleared on the exit edge so crc stays valid through FINAL.
        if (frame_end) begin
            frame_done_o = 1'b1;
            err_d        = (MODE == MODE_CHECK) && (crc != 8'h00);
            len_d        = count_q;
            count_d      = '0;
            eng_clr      = 1'b1;
            state_d      = DATA;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= DATA;
            count_q <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    assign crc_err_o   = err_q;
    assign frame_len_o = len_q;
    assign busy_o      = (state_q == FINAL) || (count_q != '0);

endmodule

// File: doc/crc8_frame_ctrl.md
Name: crc8_frame_ctrl

Overview:
Sequences a single crc8 engine over a byte stream framed by a last flag. Bytes pass through with a valid/ready handshake. Append mode emits the computed CRC byte after each frame. Check mode consumes a frame whose final byte is the received CRC and flags mismatches. The block sits between a byte source (UART/SPI deframer) and a byte sink, and owns the engine's reset and data_valid sequencing.

Parameters:
MODE, 0, 0 = append CRC byte to each frame; 1 = check frame (last byte is CRC), pass all bytes through
POLYNOMIAL, 8'h07, CRC-8 polynomial forwarded to the crc8 instance (init 0, no reflection, no xorout)
LEN_W, 16, width of frame byte counter

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; synchronous, active-high
s_data_i  in  8  input byte
s_valid_i  in  1  input byte valid
s_last_i  in  1  input byte is last of frame (qualified by s_valid_i)
s_ready_o  out  1  block accepts input byte
m_data_o  out  8  output byte
m_valid_o  out  1  output byte valid
m_last_o  out  1  output byte is last of frame
m_ready_i  in  1  sink accepts output byte
frame_done_o  out  1  one-cycle pulse at frame completion
crc_err_o  out  1  check mode: residue nonzero for last completed frame; always 0 in append mode
frame_len_o  out  LEN_W  byte count of last completed frame, saturating at 2^LEN_W-1
busy_o  out  1  high from first accepted byte until frame_done_o cycle inclusive

Behaviour:
- Reset: state=DATA, count=0. Outputs: frame_done_o=0, crc_err_o=0, frame_len_o=0, busy_o=0, m_valid_o=0. Engine rst_i asserted during rst_i.
- States: DATA, FINAL.
- DATA:
  - s_ready_o=m_ready_i; m_valid_o=s_valid_i; m_data_o=s_data_i, combinational pass-through.
  - m_last_o=s_last_i in check mode; 0 in append mode.
  - Transfer = s_valid_i & s_ready_o. Each transfer drives engine data_i=s_data_i, data_valid_i=1, and increments count (saturating).
  - Transfer with s_last_i=1 -> FINAL.
- FINAL (entered the cycle after the last transfer; engine crc_o valid this cycle):
  - s_ready_o=0.
  - Append mode: m_valid_o=1, m_data_o=crc_o, m_last_o=1; hold until m_ready_i. On handshake: frame_done_o=1, crc_err_o=0, frame_len_o=count (payload only) -> DATA.
  - Check mode: m_valid_o=0; single cycle. frame_done_o=1, crc_err_o=(crc_o!=0), frame_len_o=count (includes CRC byte) -> DATA.
- Engine reset: engine rst_i=1 on the FINAL exit cycle, so crc_o stays stable until consumed. count clears the same cycle. The next frame starts from crc 0.
- crc_err_o and frame_len_o are registered, update only on frame_done_o, and hold otherwise.
- Throughput: N-byte frame occupies N+1 cycles minimum. A back-to-back frame's first byte may transfer the cycle after FINAL exit.
- Single-byte frame (first byte with last): goes directly to FINAL; valid.
- m_ready_i low in DATA stalls input (s_ready_o=0); no byte is fed to the engine.
- m_ready_i low in append FINAL holds crc byte stable, with m_valid_o high, until accepted.
- rst_i mid-frame: partial frame discarded; engine reset; no frame_done_o; outputs return to reset values next cycle.
- s_last_i ignored when s_valid_i=0.

Decomposition:
- Package crc8_pkg: state enum (DATA, FINAL), MODE_APPEND=0 / MODE_CHECK=1 constants, CRC_INIT=8'h00.
- One sub-module: existing crc8 instance (POLYNOMIAL forwarded).
- FSM, counter and muxes live in this module.

Test Plan:
- Append, frame "123456789" (0x31..0x39), m_ready_i=1 -> 9 bytes pass through unchanged, then m_data_o=0xF4 with m_last_o=1 the cycle after byte 0x39; frame_done_o pulse, frame_len_o=9.
- Append, back-to-back frames {0x01} then {0x00}, s_valid_i held high -> output 0x01,0x07 then 0x00,0x00. Second frame's CRC is unaffected by the first (engine reset verified).
- Check, frame 0x31..0x39,0xF4 -> all 10 bytes forwarded, last byte with m_last_o=1; frame_done_o pulse with crc_err_o=0, frame_len_o=10.
- Check, frame 0x31..0x39,0xF5 -> crc_err_o=1 on frame_done_o; next good frame clears crc_err_o=0.
- Backpressure: append frame 0x31..0x39 with m_ready_i randomly toggled, including low during FINAL -> output sequence identical to the first scenario; no byte duplicated or dropped; CRC byte held stable while stalled.
- rst_i asserted after 4 bytes of a frame -> no frame_done_o. Next frame "123456789" still yields 0xF4; LEN_W=4 run of a 20-byte frame -> frame_len_o=15 (saturated).
